// File: rtl/q_maze_pkg.sv
// Shared maze types: 6x6 grid, states 1..36, actions N/E/S/W.
// Used by the path walker and the blocked-state logic.
package q_maze_pkg;

    localparam int GRID     = 6;
    localparam int N_STATES = GRID * GRID;

    typedef logic [5:0] state_t;

    typedef enum logic [1:0] {
        ACT_N = 2'd0,
        ACT_E = 2'd1,
        ACT_S = 2'd2,
        ACT_W = 2'd3
    } action_e;

    typedef enum logic [1:0] {
        STAT_NONE    = 2'd0,
        STAT_REACHED = 2'd1,
        STAT_DEAD    = 2'd2,
        STAT_LIMIT   = 2'd3
    } status_e;

    typedef enum logic [2:0] {
        S_IDLE,
        S_EMIT,
        S_READ,
        S_WAIT,
        S_DECIDE,
        S_FIN
    } walk_fsm_e;

    localparam state_t GRID_S = state_t'(GRID);
    localparam state_t LAST_S = state_t'(N_STATES);

    function automatic state_t next_state(state_t s, action_e a);
        state_t r;
        case (a)
            ACT_N:   r = s + GRID_S;
            ACT_E:   r = s + 6'd1;
            ACT_S:   r = s - GRID_S;
            default: r = s - 6'd1;
        endcase
        return r;
    endfunction

    // States are 1-based, so the east edge is s%GRID==0 and the west edge s%GRID==1
    function automatic logic move_legal(state_t s, action_e a);
        logic r;
        case (a)
            ACT_N:   r = (s <= LAST_S - GRID_S);
            ACT_E:   r = (s % GRID_S) != 6'd0;
            ACT_S:   r = (s > GRID_S);
            default: r = (s % GRID_S) != 6'd1;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/q_argmax4.sv
// Unsigned argmax over four Q values; ties resolve to the lowest index.
// zero_o flags that the winning value is zero.
module q_argmax4 #(
    parameter int W = 32
) (
    input  logic [4*W-1:0] vals_i,
    output logic [1:0]     idx_o,
    output logic           zero_o
);

    logic [W-1:0] best;

    always_comb begin
        best  = vals_i[W-1:0];
        idx_o = 2'd0;
        for (int i = 1; i < 4; i++) begin
            if (vals_i[i*W +: W] > best) begin
                best  = vals_i[i*W +: W];
                idx_o = 2'(i);
            end
        end
        zero_o = (best == '0);
    end

endmodule

// File: rtl/q_path_walker.sv
// Greedy policy walker over the masked Q-table; streams visited states.
// Define VISITED_CHECK_EN to stop on revisits. q_rd_data slice a = action a.
module q_path_walker
    import q_maze_pkg::*;
#(
    parameter int Q_W       = 32,
    parameter int GRID      = 6,
    parameter int MAX_STEPS = 36
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [5:0]       start_state,
    input  logic [5:0]       target_state,
    output logic             q_rd_en,
    output logic [5:0]       q_rd_addr,
    input  logic [4*Q_W-1:0] q_rd_data,
    output logic             path_valid,
    input  logic             path_ready,
    output logic [5:0]       path_state,
    output logic             busy,
    output logic             done,
    output logic [1:0]       status,
    output logic [5:0]       steps
);

    localparam int     NS   = GRID * GRID;
    localparam state_t LAST = state_t'(NS);
    localparam state_t MAXS = state_t'(MAX_STEPS);

    walk_fsm_e        state_q, state_d;
    state_t           cur_q, cur_d;
    state_t           tgt_q, tgt_d;
    state_t           steps_q, steps_d;
    status_e          status_q, status_d;
    logic [4*Q_W-1:0] qv_q, qv_d;
    logic [4*Q_W-1:0] masked;
    logic [1:0]       best_idx;
    logic             all_zero;
    logic             hit;
    logic             start_ok;
    state_t           nxt;

`ifdef VISITED_CHECK_EN
    logic [NS:0] visited_q, visited_d;
    assign hit = visited_q[nxt];
`else
    assign hit = 1'b0;
`endif

    always_comb begin
        for (int a = 0; a < 4; a++) begin
            masked[a*Q_W +: Q_W] = move_legal(cur_q, action_e'(a[1:0]))
                                 ? qv_q[a*Q_W +: Q_W] : '0;
        end
    end

    q_argmax4 #(.W(Q_W)) u_argmax (
        .vals_i (masked),
        .idx_o  (best_idx),
        .zero_o (all_zero)
    );

    assign nxt      = next_state(cur_q, action_e'(best_idx));
    assign start_ok = (start_state != '0) && (start_state <= LAST)
                   && (target_state != '0) && (target_state <= LAST);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= S_IDLE;
            cur_q     <= '0;
            tgt_q     <= '0;
            steps_q   <= '0;
            status_q  <= STAT_NONE;
            qv_q      <= '0;
`ifdef VISITED_CHECK_EN
            visited_q <= '0;
`endif
        end else begin
            state_q   <= state_d;
            cur_q     <= cur_d;
            tgt_q     <= tgt_d;
            steps_q   <= steps_d;
            status_q  <= status_d;
            qv_q      <= qv_d;
`ifdef VISITED_CHECK_EN
            visited_q <= visited_d;
`endif
        end
    end

    always_comb begin
        state_d   = state_q;
        cur_d     = cur_q;
        tgt_d     = tgt_q;
        steps_d   = steps_q;
        status_d  = status_q;
        qv_d      = qv_q;
`ifdef VISITED_CHECK_EN
        visited_d = visited_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    cur_d    = start_state;
                    tgt_d    = target_state;
                    steps_d  = '0;
                    status_d = STAT_NONE;
`ifdef VISITED_CHECK_EN
                    visited_d = '0;
                    if (start_ok) visited_d[start_state] = 1'b1;
`endif
                    if (start_ok) begin
                        state_d = S_EMIT;
                    end else begin
                        status_d = STAT_DEAD;
                        state_d  = S_FIN;
                    end
                end
            end
            S_EMIT: begin
                if (path_ready) begin
                    if (cur_q == tgt_q) begin
                        status_d = STAT_REACHED;
                        state_d  = S_FIN;
                    end else if (steps_q == MAXS) begin
                        status_d = STAT_LIMIT;
                        state_d  = S_FIN;
                    end else begin
                        state_d = S_READ;
                    end
                end
            end
            S_READ: state_d = S_WAIT;
            S_WAIT: begin
                qv_d    = q_rd_data;
                state_d = S_DECIDE;
            end
            S_DECIDE: begin
                if (all_zero) begin
                    status_d = STAT_DEAD;
                    state_d  = S_FIN;
                end else if (hit) begin
                    status_d = STAT_LIMIT;
                    state_d  = S_FIN;
                end else begin
`ifdef VISITED_CHECK_EN
                    visited_d[nxt] = 1'b1;
`endif
                    cur_d   = nxt;
                    steps_d = steps_q + 6'd1;
                    state_d = S_EMIT;
                end
            end
            S_FIN:   state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        path_valid = (state_q == S_EMIT);
        path_state = path_valid ? cur_q : '0;
        q_rd_en    = (state_q == S_READ);
        q_rd_addr  = q_rd_en ? cur_q : '0;
        done       = (state_q == S_FIN);
        busy       = (state_q != S_IDLE) && (state_q != S_FIN);
        status     = status_q;
        steps      = steps_q;
    end

endmodule

// File: doc/q_path_walker.md
Name: q_path_walker

Overview:
- Reads the masked Q-table produced by the maze/blocked-state logic and walks the greedy policy from start_state toward target_state.
- Streams each visited state out over a valid/ready handshake, then reports the outcome.
- Sits after Q-table training/masking. Feeds the path display and the maze-solve checker.
- Grid is 6x6. States are 1..36, index 0 is unused. Actions: 0=N (+6), 1=E (+1), 2=S (-6), 3=W (-1).

Parameters:
- Q_W, 32, width of one Q value
- GRID, 6, grid side length; N_STATES = GRID*GRID
- MAX_STEPS, 36, maximum number of moves before the walk is abandoned

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous, active-high reset
- start  in  1  one-cycle pulse that begins a walk; honoured only in IDLE
- start_state  in  6  first state, latched on start
- target_state  in  6  goal state, latched on start
- q_rd_en  out  1  Q-store read strobe
- q_rd_addr  out  6  state index to read
- q_rd_data  in  4xQ_W  Q values for actions N,E,S,W; valid the cycle after q_rd_en
- path_valid  out  1  path_state holds a valid entry
- path_ready  in  1  consumer accepts the entry
- path_state  out  6  visited state
- busy  out  1  high from start acceptance until done
- done  out  1  one-cycle pulse when the walk ends
- status  out  2  0 = none, 1 = reached, 2 = dead end/invalid, 3 = step limit/loop; held until next start
- steps  out  6  moves taken; held after done

Behaviour:
- Reset: every output is 0; FSM goes to IDLE; visited bitmap is cleared. Reset mid-walk aborts immediately and emits no done pulse.
- FSM states: IDLE, EMIT, READ, WAIT, DECIDE, FIN.
- IDLE, on start:
  - Latch start/target; cur = start_state; steps = 0; status = 0; busy = 1.
  - If start_state or target_state is 0 or > 36: go to FIN with status 2.
  - Otherwise go to EMIT.
- EMIT: path_valid=1, path_state=cur. Entry stays stable until path_valid && path_ready. After the handshake:
  - cur == target: FIN, status 1.
  - Else steps == MAX_STEPS: FIN, status 3.
  - Else: READ.
- READ: q_rd_en=1 for one cycle, q_rd_addr=cur. Go to WAIT.
- WAIT: register q_rd_data. Go to DECIDE.
- DECIDE:
  - Force legal-move masking: Q for a move off the grid is treated as 0. This covers N from 31..36, S from 1..6, E from multiples of 6, and W from 1,7,13,19,25,31.
  - Compare unsigned. Pick the max; ties go to the lowest action index.
  - If the max is 0: FIN, status 2.
  - Otherwise cur = cur + offset (6-bit arithmetic, never out of 1..36 after masking), steps += 1, go to EMIT.
- FIN: done=1 for one cycle, busy=0, go to IDLE.
- start while not IDLE is ignored.
- Latency per move: 4 cycles plus path backpressure.

Optional Feature:
- Macro VISITED_CHECK_EN.
- When defined:
  - A 37-bit visited bitmap is cleared on start and start_state is set in it.
  - In DECIDE, if the next state is already visited: FIN with status 3; the next state is not emitted and steps is not incremented.
  - Otherwise the next state's bit is set.
- When undefined: no bitmap. Loops end only at MAX_STEPS with status 3.

Decomposition:
- Shared package q_maze_pkg:
  - Action enum (N/E/S/W).
  - GRID and N_STATES constants.
  - state_t (6-bit).
  - status enum.
  - Function next_state(state, action) and function move_legal(state, action).
  - The blocked-state module also uses the package.
- One sub-module, q_argmax4: combinational 4-input unsigned argmax with lowest-index tie-break and all-zero flag.

Test Plan:
- Straight path: Q[1][E]=5, Q[2][E]=5, all else 0; start=1, target=3, path_ready=1 → stream 1,2,3; status=1; steps=2; one done pulse.
- Tie and edge masking:
  - Q[6][N]=7 and Q[6][E]=7, start=6, target=12 → stream 6,12; status 1.
  - Q[36][N]=9 only, start=36, target=1 → stream 36; status 2.
- Dead end and invalid:
  - All Q=0, start=1, target=36 → stream 1; status 2; steps 0.
  - start_state=0 → no stream; done next cycles; status 2.
- Loop: Q[1][E]=9, Q[2][W]=9, target=36.
  - With VISITED_CHECK_EN → stream 1,2; status 3; steps 1.
  - Without it → 37 entries alternating 1,2,...; status 3; steps 36.
- Backpressure: path_ready low for 5 cycles during the straight-path case → path_state held stable, no q_rd_en issued, order preserved.
- Reset mid-walk: assert rst during WAIT → all outputs 0 immediately, no done pulse. A new start afterwards runs normally; start==target=20 → stream 20; status 1.
